// File: rtl/max_reduce_uint64_stream_pkg.sv
// ---------------------------------------------------------------------------
// max_reduce_uint64_stream_pkg
// Shared definitions for the streaming max-reduction stage:
//   - DATA_W / CNT_W : default data width and element-counter width
//   - state_e        : frame FSM encoding (IDLE, ACCUM, DONE)
// Optional feature macro used by the top: MAX_REDUCE_ARGMAX_EN.
// ---------------------------------------------------------------------------
package max_reduce_uint64_stream_pkg;

   localparam int DATA_W = 64;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/gt_uint_nbit.sv
// ---------------------------------------------------------------------------
// gt_uint_nbit
// Unsigned strict greater-than comparator: gt = (a > b).
// Parameters:
//   WIDTH     : operand width
//   IMPL_TYPE : 0 = behavioural '>' operator,
//               other = explicit MSB-first priority compare
// Ports:
//   a, b : input  [WIDTH-1:0] unsigned operands
//   gt   : output             1 when a > b
// ---------------------------------------------------------------------------
module gt_uint_nbit #(
   parameter int WIDTH     = 64,
   parameter int IMPL_TYPE = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt
);

   generate
      if (IMPL_TYPE == 0) begin : g_behav
         assign gt = (a > b);
      end else begin : g_msb_first
         // The first differing bit from the MSB down decides the result.
         always_comb begin
            logic decided;
            gt      = 1'b0;
            decided = 1'b0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
               if (!decided && (a[i] != b[i])) begin
                  gt      = a[i];
                  decided = 1'b1;
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/max_reduce_uint64_stream.sv
// ---------------------------------------------------------------------------
// max_reduce_uint64_stream
// Framed streaming max reduction. Accepts one unsigned word per in_valid &
// in_ready beat, keeps a running maximum (strict greater-than, so ties keep
// the earliest occurrence) and a saturating element count, and presents one
// result per frame on a valid/ready output.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : input word valid
//   in_ready   : block can accept a word (low in DONE and during rst)
//   in_data    : unsigned element
//   in_last    : final element of the frame
//   out_valid  : frame result available (held until out_ready)
//   out_ready  : downstream accepts the result
//   out_max    : frame maximum
//   out_count  : frame element count, saturating at 2^CNT_W-1
//   out_idx    : (MAX_REDUCE_ARGMAX_EN only) zero-based position of the
//                first occurrence of the maximum, saturating like out_count
//
// Optional feature macro: MAX_REDUCE_ARGMAX_EN
// ---------------------------------------------------------------------------
module max_reduce_uint64_stream #(
   parameter int WIDTH     = max_reduce_uint64_stream_pkg::DATA_W,
   parameter int IMPL_TYPE = 0,
   parameter int CNT_W     = max_reduce_uint64_stream_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [CNT_W-1:0] out_count
`ifdef MAX_REDUCE_ARGMAX_EN
   ,
   output logic [CNT_W-1:0] out_idx
`endif
);

   import max_reduce_uint64_stream_pkg::*;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   acc_q,   acc_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
`ifdef MAX_REDUCE_ARGMAX_EN
   logic [CNT_W-1:0]   idx_q,   idx_d;
`endif

   logic acc_fire;
   logic out_fire;
   logic in_gt;
   logic cnt_sat;

   gt_uint_nbit #(
      .WIDTH     (WIDTH),
      .IMPL_TYPE (IMPL_TYPE)
   ) u_gt (
      .a  (in_data),
      .b  (acc_q),
      .gt (in_gt)
   );

   // Ready comes from registered state only, so it never combinationally
   // depends on in_valid.
   assign in_ready  = (state_q != DONE) & ~rst;
   assign out_valid = (state_q == DONE);
   assign out_max   = acc_q;
   assign out_count = cnt_q;
`ifdef MAX_REDUCE_ARGMAX_EN
   assign out_idx   = idx_q;
`endif

   assign acc_fire = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign cnt_sat  = &cnt_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
`ifdef MAX_REDUCE_ARGMAX_EN
      idx_d   = idx_q;
`endif
      case (state_q)
         IDLE: begin
            if (acc_fire) begin
               acc_d   = in_data;
               cnt_d   = CNT_W'(1);
`ifdef MAX_REDUCE_ARGMAX_EN
               idx_d   = '0;
`endif
               state_d = in_last ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (acc_fire) begin
               if (in_gt) begin
                  acc_d = in_data;
`ifdef MAX_REDUCE_ARGMAX_EN
                  // cnt_q is the zero-based position of this beat; once the
                  // counter saturates the recorded index saturates with it.
                  idx_d = cnt_q;
`endif
               end
               cnt_d   = cnt_sat ? cnt_q : cnt_q + CNT_W'(1);
               state_d = in_last ? DONE : ACCUM;
            end
         end
         DONE: begin
            if (out_fire) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
`ifdef MAX_REDUCE_ARGMAX_EN
         idx_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
`ifdef MAX_REDUCE_ARGMAX_EN
         idx_q   <= idx_d;
`endif
      end
   end

endmodule

// File: tb/tb_max_reduce_uint64_stream.sv
// ---------------------------------------------------------------------------
// tb_max_reduce_uint64_stream
// Directed-vector bench for max_reduce_uint64_stream. Two instances share
// the stimulus: dut (CNT_W=16) and dut4 (CNT_W=4) so count/index saturation
// can be seen on a short frame. Inputs change 1 time unit after the rising
// edge; outputs are sampled there too, away from the edge.
// ---------------------------------------------------------------------------
module tb_max_reduce_uint64_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready, in_ready4;
   logic [63:0] in_data;
   logic        in_last;
   logic        out_valid, out_valid4;
   logic        out_ready;
   logic [63:0] out_max, out_max4;
   logic [15:0] out_count;
   logic [3:0]  out_count4;
`ifdef MAX_REDUCE_ARGMAX_EN
   logic [15:0] out_idx;
   logic [3:0]  out_idx4;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   max_reduce_uint64_stream dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_max   (out_max),
      .out_count (out_count)
`ifdef MAX_REDUCE_ARGMAX_EN
      ,
      .out_idx   (out_idx)
`endif
   );

   max_reduce_uint64_stream #(.CNT_W(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready4),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid4),
      .out_ready (out_ready),
      .out_max   (out_max4),
      .out_count (out_count4)
`ifdef MAX_REDUCE_ARGMAX_EN
      ,
      .out_idx   (out_idx4)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One beat, accepted on the next edge (only used while not in DONE).
   task automatic send(input logic [63:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_data  = 64'hDEAD_BEEF;   // garbage while idle must be ignored
      in_last  = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Called right after the last beat; out_ready must be 1.
   task automatic result(input string tag, input logic [63:0] emax,
                         input logic [63:0] ecnt, input logic [63:0] eidx);
      chk({tag, ".valid"}, out_valid, 1'b1);
      chk({tag, ".rdy"},   in_ready,  1'b0);
      chk({tag, ".max"},   out_max,   emax);
      chk({tag, ".cnt"},   out_count, ecnt);
`ifdef MAX_REDUCE_ARGMAX_EN
      chk({tag, ".idx"},   out_idx,   eidx);
`else
      if (eidx != eidx) $display("unreachable");
`endif
      tick();
      chk({tag, ".drain"}, out_valid, 1'b0);
      chk({tag, ".rdy2"},  in_ready,  1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst.in_ready",  in_ready,  1'b0);
      chk("rst.out_valid", out_valid, 1'b0);
      chk("rst.out_max",   out_max,   64'd0);
      chk("rst.out_count", out_count, 64'd0);
      rst = 1'b0;
      #1;
      chk("rst.in_ready_after", in_ready, 1'b1);

      // Basic frame {5,9,3}
      send(64'd5, 1'b0);
      send(64'd9, 1'b0);
      chk("f1.not_yet", out_valid, 1'b0);
      send(64'd3, 1'b1);
      result("f1", 64'd9, 64'd3, 64'd1);

      // Single element at full scale
      send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      result("single", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);

      // MSB-only value must beat smaller values under unsigned compare
      send(64'd1, 1'b0);
      send(64'h8000_0000_0000_0000, 1'b0);
      send(64'd5, 1'b1);
      result("msb", 64'h8000_0000_0000_0000, 64'd3, 64'd1);

      // Ties keep the first occurrence
      send(64'd7, 1'b0);
      send(64'd7, 1'b0);
      send(64'd2, 1'b0);
      send(64'd7, 1'b1);
      result("ties", 64'd7, 64'd4, 64'd0);

      // Same frame with idle gaps carrying garbage data/last
      send(64'd7, 1'b0);
      idle(2);
      send(64'd7, 1'b0);
      idle(1);
      send(64'd2, 1'b0);
      idle(3);
      chk("gaps.hold", out_valid, 1'b0);
      send(64'd7, 1'b1);
      result("gaps", 64'd7, 64'd4, 64'd0);

      // Backpressure: result held, input blocked while in DONE
      out_ready = 1'b0;
      send(64'd4, 1'b0);
      send(64'd6, 1'b0);
      send(64'd5, 1'b1);
      in_valid = 1'b1;
      in_data  = 64'd100;
      in_last  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("bp.valid", out_valid, 1'b1);
         chk("bp.rdy",   in_ready,  1'b0);
         chk("bp.max",   out_max,   64'd6);
         chk("bp.cnt",   out_count, 64'd3);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp.last_hold", out_max, 64'd6);
      tick();
      chk("bp.drain", out_valid, 1'b0);
      send(64'd1, 1'b0);
      send(64'd2, 1'b1);
      result("bp.next", 64'd2, 64'd2, 64'd1);

      // Reset mid-frame
      send(64'd100, 1'b0);
      send(64'd200, 1'b0);
      rst = 1'b1;
      tick();
      chk("rstmid.rdy",   in_ready,  1'b0);
      chk("rstmid.valid", out_valid, 1'b0);
      chk("rstmid.max",   out_max,   64'd0);
      chk("rstmid.cnt",   out_count, 64'd0);
      rst = 1'b0;
      send(64'd3, 1'b1);
      result("rstmid.next", 64'd3, 64'd1, 64'd0);

      // Reset while a result is pending
      out_ready = 1'b0;
      send(64'd8, 1'b0);
      send(64'd1, 1'b1);
      chk("rstdone.pending", out_valid, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      chk("rstdone.valid", out_valid, 1'b0);
      chk("rstdone.max",   out_max,   64'd0);
      send(64'd11, 1'b1);
      result("rstdone.next", 64'd11, 64'd1, 64'd0);

      // 20 beats, unique max at position 17: dut4 saturates count and index
      for (int i = 0; i < 20; i++)
         send((i == 17) ? 64'd1000 : 64'(i), (i == 19));
      chk("sat4.valid", out_valid4, 1'b1);
      chk("sat4.max",   out_max4,   64'd1000);
      chk("sat4.cnt",   out_count4, 64'd15);
`ifdef MAX_REDUCE_ARGMAX_EN
      chk("sat4.idx",   out_idx4,   64'd15);
`endif
      result("sat16", 64'd1000, 64'd20, 64'd17);
      chk("sat4.drain", out_valid4, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
